// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the execute stage.
// One quotient bit per clock; result_o = {remainder, quotient}, held while start_i stays high.
module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    // state   | meaning
    // IDLE    | waiting for start_i
    // BY_ZERO | divisor was 0, result forced to 0
    // ON      | iterating, one quotient bit per edge
    // END     | result held until start_i drops
    typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_t;

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_END = CW'(DATA_W);

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [2*DATA_W:0]     work, work_n;
    logic [DATA_W-1:0]     divisor, divisor_n;
    logic                  neg_q, neg_q_n;
    logic                  neg_r, neg_r_n;
    logic [2*DATA_W-1:0]   result_n;
    logic                  ready_n;

    logic [2*DATA_W:0]     shifted;
    logic [DATA_W:0]       diff;
    logic [DATA_W-1:0]     abs_a, abs_b, quot, rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            work     <= work_n;
            divisor  <= divisor_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        work_n    = work;
        divisor_n = divisor;
        neg_q_n   = neg_q;
        neg_r_n   = neg_r;
        result_n  = result_o;
        ready_n   = ready_o;

        shifted = work << 1;
        diff    = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
        abs_a   = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        abs_b   = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        quot    = neg_q ? -work[DATA_W-1:0] : work[DATA_W-1:0];
        rem     = neg_r ? -work[2*DATA_W-1:DATA_W] : work[2*DATA_W-1:DATA_W];

        case (state)
            IDLE: begin
                ready_n  = 1'b0;
                result_n = '0;
                cnt_n    = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = BY_ZERO;
                    end else begin
                        state_n   = ON;
                        divisor_n = abs_b;
                        work_n    = {{(DATA_W+1){1'b0}}, abs_a};
                        neg_q_n   = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_r_n   = signed_div_i && opdata1_i[DATA_W-1];
                    end
                end
            end
            BY_ZERO: begin
                // result stays 0; END raises ready on the following edge
                state_n = annul_i ? IDLE : END;
            end
            ON: begin
                if (annul_i) begin
                    state_n  = IDLE;
                    ready_n  = 1'b0;
                    result_n = '0;
                end else if (cnt == CNT_END) begin
                    state_n  = END;
                    result_n = {rem, quot};
                    ready_n  = 1'b1;
                end else begin
                    // diff[DATA_W] set means the trial subtraction went negative
                    if (diff[DATA_W])
                        work_n = shifted;
                    else
                        work_n = {diff, shifted[DATA_W-1:1], 1'b1};
                    cnt_n = cnt + CW'(1);
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_n  = IDLE;
                    ready_n  = 1'b0;
                    result_n = '0;
                end else begin
                    ready_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed cases plus randomized DIV/DIVU
// operations compared against an arithmetic reference model.
module tb_ex_div;

    localparam int W = 32;
    localparam int LAT_DIV  = W + 1;
    localparam int LAT_ZERO = 2;

    logic           clk;
    logic           rst;
    logic           signed_div;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic           start;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;

    int vectors;
    int miscompares;

    ex_div #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
        end
        return {r[31:0], q[31:0]};
    endfunction

    // lat = number of edges after the start edge until ready is seen (0 = timeout)
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat);
        @(negedge clk);
        signed_div = s;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        lat        = 0;
        res        = '0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = i;
                res = result;
                break;
            end
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
        op1   = $urandom;
        op2   = $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b0 || result !== 64'd0 || dut.cnt !== '0) begin
            miscompares++;
            $display("FAIL reset: ready=%b result=%h cnt=%0d want 0/0/0", ready, result, dut.cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        logic [63:0] res;
        int lat;
        run_op(1'b0, 32'd100, 32'd7, res, lat);
        vectors++;
        if (lat !== LAT_DIV) begin
            miscompares++;
            $display("FAIL divu_latency: got %0d want %0d", lat, LAT_DIV);
        end
        vectors++;
        if (res !== {32'd2, 32'd14}) begin
            miscompares++;
            $display("FAIL divu_100_7: got %h want %h", res, {32'd2, 32'd14});
        end
        @(negedge clk);
        op1 = $urandom; op2 = $urandom; signed_div = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b1 || result !== {32'd2, 32'd14}) begin
            miscompares++;
            $display("FAIL divu_hold: ready=%b result=%h want 1/%h", ready, result, {32'd2, 32'd14});
        end
        drop_start();
        vectors++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            miscompares++;
            $display("FAIL divu_release: ready=%b result=%h want 0/0", ready, result);
        end
    endtask

    task automatic test_signed();
        logic [31:0] a_t [4];
        logic [31:0] b_t [4];
        logic [63:0] want [4];
        logic [63:0] res;
        int lat;
        a_t[0] = -32'sd7;         b_t[0] = 32'd2;          want[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        a_t[1] = 32'd7;           b_t[1] = -32'sd2;        want[1] = {32'h0000_0001, 32'hFFFF_FFFD};
        a_t[2] = 32'h8000_0000;   b_t[2] = 32'hFFFF_FFFF;  want[2] = {32'h0, 32'h8000_0000};
        a_t[3] = -32'sd7;         b_t[3] = -32'sd2;        want[3] = {32'hFFFF_FFFF, 32'h0000_0003};
        for (int k = 0; k < 4; k++) begin
            run_op(1'b1, a_t[k], b_t[k], res, lat);
            vectors++;
            if (res !== want[k] || lat !== LAT_DIV) begin
                miscompares++;
                $display("FAIL div_signed[%0d]: got %h lat %0d want %h lat %0d", k, res, lat, want[k], LAT_DIV);
            end
            drop_start();
        end
    endtask

    task automatic test_unsigned_edges();
        logic [31:0] a_t [2];
        logic [31:0] b_t [2];
        logic [63:0] want [2];
        logic [63:0] res;
        int lat;
        a_t[0] = 32'hFFFF_FFFF; b_t[0] = 32'd1;          want[0] = {32'h0, 32'hFFFF_FFFF};
        a_t[1] = 32'd5;         b_t[1] = 32'hFFFF_FFFF;  want[1] = {32'd5, 32'h0};
        for (int k = 0; k < 2; k++) begin
            run_op(1'b0, a_t[k], b_t[k], res, lat);
            vectors++;
            if (res !== want[k] || lat !== LAT_DIV) begin
                miscompares++;
                $display("FAIL divu_edge[%0d]: got %h lat %0d want %h lat %0d", k, res, lat, want[k], LAT_DIV);
            end
            drop_start();
        end
    endtask

    task automatic test_by_zero();
        logic [63:0] res;
        int lat;
        logic saw_iter;
        saw_iter = 1'b0;
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'h1234; op2 = 32'd0; start = 1'b1;
        lat = 0; res = '1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (dut.cnt !== '0) saw_iter = 1'b1;
            if (ready) begin
                lat = i;
                res = result;
                break;
            end
        end
        vectors++;
        if (lat !== LAT_ZERO || res !== 64'd0) begin
            miscompares++;
            $display("FAIL by_zero: lat %0d result %h want lat %0d result 0", lat, res, LAT_ZERO);
        end
        vectors++;
        if (saw_iter !== 1'b0) begin
            miscompares++;
            $display("FAIL by_zero_no_iter: iterations seen=%b want 0", saw_iter);
        end
        drop_start();
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        logic saw_ready;
        saw_ready = 1'b0;
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (11) begin
            @(posedge clk);
            #1;
            if (ready) saw_ready = 1'b1;
        end
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b0 || result !== 64'd0 || saw_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL annul: ready=%b result=%h early_ready=%b want 0/0/0", ready, result, saw_ready);
        end
        @(negedge clk);
        annul = 1'b0;
        run_op(1'b0, 32'd9, 32'd3, res, lat);
        vectors++;
        if (res !== {32'd0, 32'd3} || lat !== LAT_DIV) begin
            miscompares++;
            $display("FAIL annul_restart: got %h lat %0d want %h lat %0d", res, lat, {32'd0, 32'd3}, LAT_DIV);
        end
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            miscompares++;
            $display("FAIL annul_end: ready=%b result=%h want 0/0", ready, result);
        end
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_async_reset();
        logic [63:0] res;
        int lat;
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (12) @(posedge clk);
        #3;
        rst = 1'b1; start = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b0 || result !== 64'd0 || dut.cnt !== '0) begin
            miscompares++;
            $display("FAIL async_rst_on: ready=%b result=%h cnt=%0d want 0/0/0", ready, result, dut.cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 32'd100, 32'd7, res, lat);
        vectors++;
        if (res !== {32'd2, 32'd14} || lat !== LAT_DIV) begin
            miscompares++;
            $display("FAIL async_rst_recover: got %h lat %0d want %h lat %0d", res, lat, {32'd2, 32'd14}, LAT_DIV);
        end
        #2;
        rst = 1'b1; start = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            miscompares++;
            $display("FAIL async_rst_end: ready=%b result=%h want 0/0", ready, result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic s;
        logic [63:0] res;
        logic [63:0] want;
        int lat;
        int want_lat;
        for (int k = 0; k < 40; k++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -32'($urandom_range(1, 15));
                3: b = 32'hFFFF_FFFF;
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            want     = ref_div(s, a, b);
            want_lat = (b == 32'd0) ? LAT_ZERO : LAT_DIV;
            run_op(s, a, b, res, lat);
            vectors++;
            if (res !== want || lat !== want_lat) begin
                miscompares++;
                $display("FAIL random[%0d] s=%b %h/%h: got %h lat %0d want %h lat %0d",
                         k, s, a, b, res, lat, want, want_lat);
            end
            drop_start();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_unsigned_edges();
        test_by_zero();
        test_annul();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
